lab2_proc_scoreboard_bypass: RTL and testbench

//  Parametrised hazard scoreboard plus operand bypass network for the pipelined TinyRV2 cores.
//  - Tracks in-flight register writers across p_nstages post-decode stages (default X, M, W).
//  - Per D-stage read port, either:
//    - selects the youngest ready producer's value, or
//    - raises a per-port stall when the producer's result is not yet available.
//  - Replaces hand-coded bypass muxes/stall logic; supports variable producer latency (ALU, load, imul).

---
 rtl/lab2_proc_scoreboard_bypass.sv | 169 ++++++++++++++++
 tb/tb_lab2_proc_scoreboard_bypass.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_scoreboard_bypass.sv
`default_nettype none
// ============================================================================
// Module   : lab2_proc_scoreboard_bypass
// Brief    : Hazard scoreboard and operand bypass network for pipelined TinyRV2.
//            Optional LAB2_PROC_SB_STATS_EN adds stall/bypass event counters.
// Revision : 1.0 - initial release
// ============================================================================
module lab2_proc_scoreboard_bypass #(
    parameter int p_nstages    = 3,
    parameter int p_nread      = 2,
    parameter int p_data_nbits = 32,
    parameter int p_addr_nbits = 5,
    localparam int c_LAT_NBITS = (p_nstages > 1) ? $clog2(p_nstages) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            adv,
    input  logic                            issue_val,
    input  logic                            issue_wen,
    input  logic [p_addr_nbits-1:0]         issue_waddr,
    input  logic [c_LAT_NBITS-1:0]          issue_lat,
    input  logic                            squash_X,
    input  logic [p_nread*p_addr_nbits-1:0] rs_addr,
    input  logic [p_nread*p_data_nbits-1:0] rf_rdata,
    input  logic [p_nstages*p_data_nbits-1:0] stage_data,
    output logic [p_nread*p_data_nbits-1:0] op_data,
    output logic [p_nread-1:0]              op_stall,
    output logic [31:0]                     stall_count,
    output logic [31:0]                     bypass_count
);

    // ------------------------------------------------------------------
    // Tracked writer entries, index 0 = X (youngest), p_nstages-1 = W
    // ------------------------------------------------------------------
    logic [p_nstages-1:0]    val_q;
    logic [p_nstages-1:0]    val_d;
    logic [p_addr_nbits-1:0] waddr_q [p_nstages];
    logic [p_addr_nbits-1:0] waddr_d [p_nstages];
    logic [c_LAT_NBITS-1:0]  lat_q   [p_nstages];
    logic [c_LAT_NBITS-1:0]  lat_d   [p_nstages];
    logic                    w_issue_rec;
    logic [p_nstages-1:0]    w_stage_rdy;

    // Writes to x0 are architecturally discarded, so they never create hazards.
    assign w_issue_rec = issue_val & issue_wen & (issue_waddr != '0);

    always_comb begin
        val_d   = val_q;
        waddr_d = waddr_q;
        lat_d   = lat_q;
        if (adv) begin
            for (int k = p_nstages - 1; k > 0; k--) begin
                val_d[k]   = val_q[k-1] & ~(squash_X && (k == 1));
                waddr_d[k] = waddr_q[k-1];
                lat_d[k]   = lat_q[k-1];
            end
            val_d[0]   = w_issue_rec;
            waddr_d[0] = issue_waddr;
            lat_d[0]   = issue_lat;
        end else if (squash_X) begin
            val_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q   <= '0;
            waddr_q <= '{default: '0};
            lat_q   <= '{default: '0};
        end else begin
            val_q   <= val_d;
            waddr_q <= waddr_d;
            lat_q   <= lat_d;
        end
    end

    for (genvar k = 0; k < p_nstages; k++) begin : g_stage
        assign w_stage_rdy[k] = (c_LAT_NBITS'(k) >= lat_q[k]);
    end

`ifdef LAB2_PROC_SB_STATS_EN
    logic [p_nread-1:0] w_byp;
`endif

    // ------------------------------------------------------------------
    // Per-port lookup: the lowest matching stage is the youngest writer
    // ------------------------------------------------------------------
    for (genvar i = 0; i < p_nread; i++) begin : g_port
        logic [p_addr_nbits-1:0] w_ra;
        logic [p_data_nbits-1:0] w_rf;
        logic [p_data_nbits-1:0] w_sd;
        logic                    w_hit;
        logic                    w_rdy;
        logic                    w_zero;

        assign w_ra   = rs_addr[i*p_addr_nbits +: p_addr_nbits];
        assign w_rf   = rf_rdata[i*p_data_nbits +: p_data_nbits];
        assign w_zero = (w_ra == '0);

        always_comb begin
            w_hit = 1'b0;
            w_rdy = 1'b0;
            w_sd  = '0;
            for (int k = p_nstages - 1; k >= 0; k--) begin
                if (val_q[k] && (waddr_q[k] == w_ra)) begin
                    w_hit = 1'b1;
                    w_rdy = w_stage_rdy[k];
                    w_sd  = stage_data[k*p_data_nbits +: p_data_nbits];
                end
            end
        end

        // Reset masks any stale entries still visible during the reset cycle.
        assign op_stall[i] = ~reset & ~w_zero & w_hit & ~w_rdy;
        assign op_data[i*p_data_nbits +: p_data_nbits] =
            reset  ? w_rf :
            w_zero ? '0   :
            w_hit  ? w_sd : w_rf;

`ifdef LAB2_PROC_SB_STATS_EN
        assign w_byp[i] = ~reset & ~w_zero & w_hit & w_rdy;
`endif
    end

    // ------------------------------------------------------------------
    // Optional event counters
    // ------------------------------------------------------------------
`ifdef LAB2_PROC_SB_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] byp_cnt_q;
    logic [31:0] byp_cnt_d;
    logic [31:0] w_byp_inc;

    always_comb begin
        w_byp_inc = '0;
        for (int i = 0; i < p_nread; i++) begin
            w_byp_inc = w_byp_inc + 32'(w_byp[i]);
        end
        stall_cnt_d = stall_cnt_q + 32'(|op_stall);
        byp_cnt_d   = byp_cnt_q + w_byp_inc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            byp_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            byp_cnt_q   <= byp_cnt_d;
        end
    end

    assign stall_count  = stall_cnt_q;
    assign bypass_count = byp_cnt_q;
`else
    assign stall_count  = '0;
    assign bypass_count = '0;
`endif

    // A latency beyond the last stage would never become ready.
    always_ff @(posedge clk) begin
        if (!reset && adv && issue_val) begin
            assert (int'(issue_lat) < p_nstages);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lab2_proc_scoreboard_bypass.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab2_proc_scoreboard_bypass
// Brief    : Vector table, corner sequences and random run against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lab2_proc_scoreboard_bypass;

    localparam int NS = 3;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [31:0] RF0 = 32'h0000_000A;
    localparam logic [31:0] RF1 = 32'h0000_000B;
    localparam logic [31:0] SD0 = 32'h0000_0100;
    localparam logic [31:0] SD1 = 32'h0000_0200;
    localparam logic [31:0] SD2 = 32'h0000_0300;

    logic              clk = 1'b0;
    logic              reset;
    logic              adv;
    logic              issue_val;
    logic              issue_wen;
    logic [AW-1:0]     issue_waddr;
    logic [1:0]        issue_lat;
    logic              squash_X;
    logic [NR*AW-1:0]  rs_addr;
    logic [NR*DW-1:0]  rf_rdata;
    logic [NS*DW-1:0]  stage_data;
    logic [NR*DW-1:0]  op_data;
    logic [NR-1:0]     op_stall;
    logic [31:0]       stall_count;
    logic [31:0]       bypass_count;

    int n_tests = 0;
    int n_fail  = 0;

    lab2_proc_scoreboard_bypass #(
        .p_nstages   (NS),
        .p_nread     (NR),
        .p_data_nbits(DW),
        .p_addr_nbits(AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .adv         (adv),
        .issue_val   (issue_val),
        .issue_wen   (issue_wen),
        .issue_waddr (issue_waddr),
        .issue_lat   (issue_lat),
        .squash_X    (squash_X),
        .rs_addr     (rs_addr),
        .rf_rdata    (rf_rdata),
        .stage_data  (stage_data),
        .op_data     (op_data),
        .op_stall    (op_stall),
        .stall_count (stall_count),
        .bypass_count(bypass_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef LAB2_PROC_SB_STATS_EN
        return v;
`else
        return 32'(v & 32'h0);
`endif
    endfunction

    // ------------------------------------------------------------------
    // Reference model: a 3-deep queue of in-flight writers, front = X
    // ------------------------------------------------------------------
    typedef struct packed {
        logic          val;
        logic [AW-1:0] addr;
        logic [1:0]    lat;
    } ent_t;

    ent_t        pipe[$];
    logic [31:0] m_stall;
    logic [31:0] m_byp;

    task automatic model_clear();
        pipe = {};
        for (int k = 0; k < NS; k++) pipe.push_back('0);
        m_stall = '0;
        m_byp   = '0;
    endtask

    function automatic void ref_port(input logic [AW-1:0] ra, input logic [DW-1:0] rf,
                                     output logic st, output logic [DW-1:0] d,
                                     output logic byp);
        st  = 1'b0;
        byp = 1'b0;
        d   = rf;
        if (reset) return;
        if (ra == '0) begin
            d = '0;
            return;
        end
        for (int k = 0; k < NS; k++) begin
            if (pipe[k].val && pipe[k].addr == ra) begin
                d = stage_data[k*DW +: DW];
                if (k >= int'(pipe[k].lat)) byp = 1'b1;
                else                        st  = 1'b1;
                return;
            end
        end
    endfunction

    task automatic model_edge(input logic any_st, input int nbyp);
        ent_t e;
        if (reset) begin
            model_clear();
        end else begin
            m_stall = m_stall + 32'(any_st);
            m_byp   = m_byp + 32'(nbyp);
            if (adv || squash_X) begin
                e = pipe[0];
                if (squash_X) e.val = 1'b0;
                pipe[0] = e;
            end
            if (adv) begin
                void'(pipe.pop_back());
                e.val  = issue_val & issue_wen & (issue_waddr != '0);
                e.addr = issue_waddr;
                e.lat  = issue_lat;
                pipe.push_front(e);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic          adv;
        logic          iv;
        logic          iw;
        logic [AW-1:0] wa;
        logic [1:0]    lat;
        logic          sq;
        logic [AW-1:0] rs0;
        logic [AW-1:0] rs1;
        logic [1:0]    est;
        logic [31:0]   ed0;
        logic [31:0]   ed1;
    } vec_t;

    vec_t tv[27];

    function automatic vec_t mk(input int a, input int iv, input int iw, input int wa,
                                input int lat, input int sq, input int rs0, input int rs1,
                                input int est, input logic [31:0] ed0, input logic [31:0] ed1);
        vec_t v;
        v.adv = 1'(a);   v.iv  = 1'(iv);  v.iw  = 1'(iw);
        v.wa  = 5'(wa);  v.lat = 2'(lat); v.sq  = 1'(sq);
        v.rs0 = 5'(rs0); v.rs1 = 5'(rs1); v.est = 2'(est);
        v.ed0 = ed0;     v.ed1 = ed1;
        return v;
    endfunction

    task automatic idle_inputs();
        adv = 1'b0; issue_val = 1'b0; issue_wen = 1'b0; issue_waddr = '0;
        issue_lat = '0; squash_X = 1'b0; rs_addr = '0;
        rf_rdata = {RF1, RF0};
        stage_data = {SD2, SD1, SD0};
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        adv = v.adv; issue_val = v.iv; issue_wen = v.iw; issue_waddr = v.wa;
        issue_lat = v.lat; squash_X = v.sq; rs_addr = {v.rs1, v.rs0};
        #3;
        chk($sformatf("vec%0d stall", idx), 32'(op_stall), 32'(v.est));
        if (!v.est[0]) chk($sformatf("vec%0d data0", idx), op_data[DW-1:0], v.ed0);
        if (!v.est[1]) chk($sformatf("vec%0d data1", idx), op_data[2*DW-1:DW], v.ed1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic          st [NR];
        logic [DW-1:0] d  [NR];
        logic          bp [NR];
        int            nb;

        idle_inputs();
        reset = 1'b1;
        rs_addr = {5'd3, 5'd5};
        repeat (2) @(posedge clk);
        #1;
        #3;
        chk("reset data", op_data[DW-1:0], RF0);
        chk("reset stall", 32'(op_stall), 32'd0);
        chk("reset stall_count", stall_count, 32'd0);
        chk("reset bypass_count", bypass_count, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        //            adv iv iw wa lat sq rs0 rs1 est ed0  ed1
        tv[0]  = mk(0, 0, 0, 0, 0, 0, 5, 3, 0, RF0, RF1);
        tv[1]  = mk(1, 1, 1, 5, 0, 0, 5, 3, 0, RF0, RF1);
        tv[2]  = mk(1, 0, 0, 0, 0, 0, 5, 3, 0, SD0, RF1);
        tv[3]  = mk(1, 0, 0, 0, 0, 0, 5, 3, 0, SD1, RF1);
        tv[4]  = mk(1, 0, 0, 0, 0, 0, 5, 3, 0, SD2, RF1);
        tv[5]  = mk(0, 0, 0, 0, 0, 0, 5, 3, 0, RF0, RF1);
        tv[6]  = mk(1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        tv[7]  = mk(0, 1, 1, 7, 0, 0, 3, 7, 2, RF0, 0);
        tv[8]  = mk(0, 0, 0, 0, 0, 0, 3, 7, 2, RF0, 0);
        tv[9]  = mk(1, 0, 0, 0, 0, 0, 3, 7, 2, RF0, 0);
        tv[10] = mk(0, 0, 0, 0, 0, 0, 3, 7, 0, RF0, SD1);
        tv[11] = mk(1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        tv[12] = mk(1, 1, 1, 4, 0, 0, 4, 7, 0, SD0, SD2);
        tv[13] = mk(0, 0, 0, 0, 0, 0, 4, 4, 0, SD0, SD0);
        tv[14] = mk(1, 1, 1, 4, 1, 0, 4, 3, 0, SD0, RF1);
        tv[15] = mk(0, 0, 0, 0, 0, 0, 4, 4, 3, 0, 0);
        tv[16] = mk(1, 1, 1, 9, 0, 1, 0, 0, 0, 0, 0);
        tv[17] = mk(0, 0, 0, 0, 0, 0, 4, 9, 0, SD2, SD0);
        tv[18] = mk(1, 0, 0, 0, 0, 1, 9, 3, 0, SD0, RF1);
        tv[19] = mk(0, 0, 0, 0, 0, 0, 9, 4, 0, RF0, RF1);
        tv[20] = mk(1, 1, 1, 6, 0, 0, 9, 4, 0, RF0, RF1);
        tv[21] = mk(0, 0, 0, 0, 0, 1, 6, 3, 0, SD0, RF1);
        tv[22] = mk(0, 0, 0, 0, 0, 0, 6, 3, 0, RF0, RF1);
        tv[23] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[24] = mk(0, 0, 0, 0, 0, 0, 0, 6, 0, 0, RF1);
        tv[25] = mk(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        tv[26] = mk(0, 0, 0, 0, 0, 0, 3, 0, 0, RF0, 0);

        for (int i = 0; i < 27; i++) apply_vec(tv[i], i);

        // Reset mid-flight: X holds x6 (load), M holds x5
        idle_inputs();
        adv = 1'b1; issue_val = 1'b1; issue_wen = 1'b1; issue_waddr = 5'd5; issue_lat = 2'd0;
        @(posedge clk); #1;
        issue_waddr = 5'd6; issue_lat = 2'd1;
        @(posedge clk); #1;
        adv = 1'b0; issue_val = 1'b0; rs_addr = {5'd6, 5'd5};
        #3;
        chk("midflight M bypass", op_data[DW-1:0], SD1);
        chk("midflight X stall", 32'(op_stall), 32'd2);
        reset = 1'b1; adv = 1'b1; issue_val = 1'b1; issue_waddr = 5'd8;
        #1;
        chk("in-reset data0", op_data[DW-1:0], RF0);
        chk("in-reset data1", op_data[2*DW-1:DW], RF1);
        chk("in-reset stall", 32'(op_stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; adv = 1'b0; issue_val = 1'b0;
        rs_addr = {5'd6, 5'd5};
        #3;
        chk("post-reset data0", op_data[DW-1:0], RF0);
        chk("post-reset data1", op_data[2*DW-1:DW], RF1);
        chk("post-reset stall", 32'(op_stall), 32'd0);
        chk("post-reset stall_count", stall_count, 32'd0);
        @(posedge clk); #1;

        // Counter scenario: one stall cycle, then a single-port bypass
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        adv = 1'b1; issue_val = 1'b1; issue_wen = 1'b1; issue_waddr = 5'd7; issue_lat = 2'd1;
        @(posedge clk); #1;
        issue_val = 1'b0; rs_addr = {5'd7, 5'd0};
        #3;
        chk("stats stall", 32'(op_stall), 32'd2);
        @(posedge clk); #1;
        adv = 1'b0;
        #3;
        chk("stats bypass stall", 32'(op_stall), 32'd0);
        chk("stats bypass data", op_data[2*DW-1:DW], SD1);
        @(posedge clk); #1;
        rs_addr = '0;
        #3;
        chk("stall_count", stall_count, exp_cnt(32'd1));
        chk("bypass_count", bypass_count, exp_cnt(32'd1));

        // Randomised run against the model
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 63) == 0);
            adv         = ($urandom_range(0, 9) < 7);
            issue_val   = ($urandom_range(0, 3) != 0);
            issue_wen   = ($urandom_range(0, 3) != 0);
            issue_waddr = 5'($urandom_range(0, 7));
            issue_lat   = 2'($urandom_range(0, NS - 1));
            squash_X    = ($urandom_range(0, 9) == 0);
            rs_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rf_rdata    = {$urandom(), $urandom()};
            stage_data  = {$urandom(), $urandom(), $urandom()};
            #3;
            nb = 0;
            for (int i = 0; i < NR; i++) begin
                ref_port(rs_addr[i*AW +: AW], rf_rdata[i*DW +: DW], st[i], d[i], bp[i]);
                nb += int'(bp[i]);
                if (!st[i]) chk($sformatf("rand c%0d data%0d", c, i), op_data[i*DW +: DW], d[i]);
            end
            chk($sformatf("rand c%0d stall", c), 32'(op_stall), 32'({st[1], st[0]}));
            chk($sformatf("rand c%0d stall_count", c), stall_count, exp_cnt(m_stall));
            chk($sformatf("rand c%0d bypass_count", c), bypass_count, exp_cnt(m_byp));
            @(posedge clk);
            model_edge(st[0] | st[1], nb);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
